// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    // Control state of the unit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Operation latched at start.
    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Widest vector twos_neg handles; the product path needs 2*WIDTH, so WIDTH <= 64.
    localparam int MAX_W = 128;

    // Two's-complement negation; callers zero-extend into MAX_W and truncate back.
    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
        return ~v + MAX_W'(1);
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the magnitude datapath: add-shift for multiply,
// trial-subtract-shift (restoring) for divide.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        trial   = shifted - {1'b0, addend};
        if (op == OP_MULT) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            // remainder < divisor <= 2^(WIDTH-1), so shifted never sets its top bit
            // and a set top bit of trial means the subtraction went negative
            nxt_hi = trial[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit with start/ready handshake.
// Works on operand magnitudes, one bit per cycle, and applies the sign
// when the result is presented in DONE.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             cancel,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return WIDTH'(twos_neg(MAX_W'(v)));
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return (2*WIDTH)'(twos_neg(MAX_W'(v)));
    endfunction

    state_t            state_q, state_d;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              div_zero_q;
    logic              a_min_q;
    logic              b_ones_q;
    logic [WIDTH-1:0]  addend_q;
    logic [WIDTH-1:0]  acc_hi_q;
    logic [WIDTH-1:0]  acc_lo_q;
    logic [WIDTH-1:0]  result_q;
    logic              exc_q;

    logic              start_ok;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [WIDTH-1:0]  step_hi;
    logic [WIDTH-1:0]  step_lo;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]  quot_s;
    logic [WIDTH-1:0]  fin_result;
    logic              fin_exc;

    // A start is taken in IDLE, and also on the DONE exit edge for back-to-back issue.
    assign start_ok = ((state_q == IDLE) || (state_q == DONE)) && !cancel
                      && (ctrl_MULT || ctrl_DIV);

    // Operand magnitudes; MIN_INT maps to 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        mag_a = data_operandA[WIDTH-1] ? neg_w(data_operandA) : data_operandA;
        mag_b = data_operandB[WIDTH-1] ? neg_w(data_operandB) : data_operandB;
    end

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_q),
        .acc_hi (acc_hi_q),
        .acc_lo (acc_lo_q),
        .addend (addend_q),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Sign fix-up and exception flags for the finished operation.
    always_comb begin
        prod_mag   = {acc_hi_q, acc_lo_q};
        prod_s     = neg_q ? neg_2w(prod_mag) : prod_mag;
        quot_s     = neg_q ? neg_w(acc_lo_q) : acc_lo_q;
        fin_result = quot_s;
        fin_exc    = 1'b0;
        if (op_q == OP_MULT) begin
            fin_result = prod_s[WIDTH-1:0];
            fin_exc    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
        end else if (div_zero_q) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else if (a_min_q && b_ones_q) begin
            fin_result = MIN_INT;
            fin_exc    = 1'b1;
        end
    end

    // Next-state logic; the counter sits at WIDTH for one extra RUN cycle so
    // DONE lands on edge WIDTH+1 after capture.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = RUN;
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = start_ok ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture registers, iteration datapath and held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            a_min_q    <= 1'b0;
            b_ones_q   <= 1'b0;
            addend_q   <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            result_q   <= '0;
            exc_q      <= 1'b0;
        end else begin
            if (start_ok) begin
                op_q       <= ctrl_MULT ? OP_MULT : OP_DIV;
                cnt_q      <= '0;
                neg_q      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero_q <= (data_operandB == '0);
                a_min_q    <= (data_operandA == MIN_INT);
                b_ones_q   <= &data_operandB;
                addend_q   <= ctrl_MULT ? mag_a : mag_b;
                acc_hi_q   <= '0;
                acc_lo_q   <= ctrl_MULT ? mag_b : mag_a;
            end else if ((state_q == RUN) && !cancel && (cnt_q != LAST_CNT)) begin
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
            if (data_resultRDY) begin
                result_q <= fin_result;
                exc_q    <= fin_exc;
            end
        end
    end

    // Result is shown live during DONE so a same-cycle cancel can withhold it.
    assign busy           = (state_q == RUN);
    assign data_resultRDY = (state_q == DONE) && !cancel;
    assign data_result    = data_resultRDY ? fin_result : result_q;
    assign data_exception = data_resultRDY ? fin_exc : exc_q;

endmodule
